// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register: latches the ID instruction, operands and exception info, and
// registers the decoded hazard metadata (A1/A2/A3, result class, Tnew) for downstream hazard and forwarding logic.
module idex_stage_reg #(
  parameter logic [31:0] RESET_PCP4 = 32'h0000_3004,
  parameter logic [4:0]  EXC_RI     = 5'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] IR_IFID,
  input  logic [31:0] PCp4_IFID,
  input  logic        BD_IFID,
  input  logic [4:0]  ExcCode_IFID,
  input  logic [31:0] RD1_ID,
  input  logic [31:0] RD2_ID,
  input  logic [31:0] EXT_ID,
  output logic [31:0] IR_IDEX,
  output logic [31:0] PCp4_IDEX,
  output logic [31:0] RS_IDEX,
  output logic [31:0] RT_IDEX,
  output logic [31:0] EXT_IDEX,
  output logic [4:0]  A1_IDEX,
  output logic [4:0]  A2_IDEX,
  output logic [4:0]  A3_IDEX,
  output logic [1:0]  Res_IDEX,
  output logic [1:0]  Tnew_IDEX,
  output logic        BD_IDEX,
  output logic [4:0]  ExcCode_IDEX
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 2;

  localparam logic [CW-1:0] RES_NW  = 2'b00;
  localparam logic [CW-1:0] RES_ALU = 2'b01;
  localparam logic [CW-1:0] RES_DM  = 2'b10;
  localparam logic [CW-1:0] RES_PC  = 2'b11;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_JAL     = 6'h03;

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [RW-1:0] rs_f;
  logic [RW-1:0] rt_f;
  logic [RW-1:0] rd_f;

  assign op    = IR_IFID[31:26];
  assign rs_f  = IR_IFID[25:21];
  assign rt_f  = IR_IFID[20:16];
  assign rd_f  = IR_IFID[15:11];
  assign funct = IR_IFID[5:0];

  logic [RW-1:0] dec_a3;
  logic [CW-1:0] dec_cls;
  logic [CW-1:0] dec_res;
  logic [CW-1:0] dec_tnew;
  logic [RW-1:0] dec_exc;
  logic          dec_legal;

  // Instruction class decode: destination register and result class.
  always_comb begin
    dec_a3    = '0;
    dec_cls   = RES_NW;
    dec_legal = 1'b1;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h10, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b: begin
            dec_a3  = rd_f;
            dec_cls = RES_ALU;
          end
          6'h09: begin
            dec_a3  = rd_f;
            dec_cls = RES_PC;
          end
          6'h08, 6'h0c, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: ;
          default: dec_legal = 1'b0;
        endcase
      end
      OP_REGIMM: dec_legal = (rt_f == 5'd0) || (rt_f == 5'd1);
      OP_JAL: begin
        dec_a3  = 5'd31;
        dec_cls = RES_PC;
      end
      6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h28, 6'h29, 6'h2b: ;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        dec_a3  = rt_f;
        dec_cls = RES_ALU;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec_a3  = rt_f;
        dec_cls = RES_DM;
      end
      OP_COP0: begin
        if (rs_f == 5'd0) begin
          dec_a3  = rt_f;
          dec_cls = RES_DM;
        end else if (rs_f == 5'd4) begin
          dec_cls = RES_NW;
        end else if (rs_f[4] && funct == 6'h18) begin
          dec_cls = RES_NW;
        end else begin
          dec_legal = 1'b0;
        end
      end
      default: dec_legal = 1'b0;
    endcase

    if (!dec_legal) begin
      dec_a3  = '0;
      dec_cls = RES_NW;
    end

    dec_res = dec_cls;
    case (dec_cls)
      RES_ALU: dec_tnew = 2'd1;
      RES_DM:  dec_tnew = 2'd2;
      default: dec_tnew = 2'd0;
    endcase
    // A zero destination never produces a forwardable result.
    if (dec_a3 == '0) begin
      dec_res  = RES_NW;
      dec_tnew = 2'd0;
    end

    if (ExcCode_IFID != '0) dec_exc = ExcCode_IFID;
    else if (!dec_legal)     dec_exc = EXC_RI;
    else                     dec_exc = '0;
  end

  logic [DW-1:0] ir_d,   ir_q;
  logic [DW-1:0] pcp4_d, pcp4_q;
  logic [DW-1:0] rs_d,   rs_q;
  logic [DW-1:0] rt_d,   rt_q;
  logic [DW-1:0] ext_d,  ext_q;
  logic [RW-1:0] a1_d,   a1_q;
  logic [RW-1:0] a2_d,   a2_q;
  logic [RW-1:0] a3_d,   a3_q;
  logic [CW-1:0] res_d,  res_q;
  logic [CW-1:0] tnew_d, tnew_q;
  logic          bd_d,   bd_q;
  logic [RW-1:0] exc_d,  exc_q;

  // Next-state: normal load, or a bubble that still carries PC+4/BD as the EPC source.
  always_comb begin
    ir_d   = IR_IFID;
    pcp4_d = PCp4_IFID;
    rs_d   = RD1_ID;
    rt_d   = RD2_ID;
    ext_d  = EXT_ID;
    a1_d   = rs_f;
    a2_d   = rt_f;
    a3_d   = dec_a3;
    res_d  = dec_res;
    tnew_d = dec_tnew;
    bd_d   = BD_IFID;
    exc_d  = dec_exc;
    if (stall) begin
      ir_d   = '0;
      rs_d   = '0;
      rt_d   = '0;
      ext_d  = '0;
      a1_d   = '0;
      a2_d   = '0;
      a3_d   = '0;
      res_d  = RES_NW;
      tnew_d = '0;
      exc_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ir_q   <= '0;
      pcp4_q <= RESET_PCP4;
      rs_q   <= '0;
      rt_q   <= '0;
      ext_q  <= '0;
      a1_q   <= '0;
      a2_q   <= '0;
      a3_q   <= '0;
      res_q  <= RES_NW;
      tnew_q <= '0;
      bd_q   <= 1'b0;
      exc_q  <= '0;
    end else begin
      ir_q   <= ir_d;
      pcp4_q <= pcp4_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      ext_q  <= ext_d;
      a1_q   <= a1_d;
      a2_q   <= a2_d;
      a3_q   <= a3_d;
      res_q  <= res_d;
      tnew_q <= tnew_d;
      bd_q   <= bd_d;
      exc_q  <= exc_d;
    end
  end

  assign IR_IDEX      = ir_q;
  assign PCp4_IDEX    = pcp4_q;
  assign RS_IDEX      = rs_q;
  assign RT_IDEX      = rt_q;
  assign EXT_IDEX     = ext_q;
  assign A1_IDEX      = a1_q;
  assign A2_IDEX      = a2_q;
  assign A3_IDEX      = a3_q;
  assign Res_IDEX     = res_q;
  assign Tnew_IDEX    = tnew_q;
  assign BD_IDEX      = bd_q;
  assign ExcCode_IDEX = exc_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Directed bench for idex_stage_reg: reset, stall bubble, flush priority, RI detection,
// forced-zero destination and a short run of random legal instructions against a class table.
module tb_idex_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] IR_IFID, PCp4_IFID, RD1_ID, RD2_ID, EXT_ID;
  logic        BD_IFID;
  logic [4:0]  ExcCode_IFID;
  logic [31:0] IR_IDEX, PCp4_IDEX, RS_IDEX, RT_IDEX, EXT_IDEX;
  logic [4:0]  A1_IDEX, A2_IDEX, A3_IDEX, ExcCode_IDEX;
  logic [1:0]  Res_IDEX, Tnew_IDEX;
  logic        BD_IDEX;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  idex_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .IR_IFID(IR_IFID), .PCp4_IFID(PCp4_IFID), .BD_IFID(BD_IFID), .ExcCode_IFID(ExcCode_IFID),
    .RD1_ID(RD1_ID), .RD2_ID(RD2_ID), .EXT_ID(EXT_ID),
    .IR_IDEX(IR_IDEX), .PCp4_IDEX(PCp4_IDEX), .RS_IDEX(RS_IDEX), .RT_IDEX(RT_IDEX),
    .EXT_IDEX(EXT_IDEX), .A1_IDEX(A1_IDEX), .A2_IDEX(A2_IDEX), .A3_IDEX(A3_IDEX),
    .Res_IDEX(Res_IDEX), .Tnew_IDEX(Tnew_IDEX), .BD_IDEX(BD_IDEX), .ExcCode_IDEX(ExcCode_IDEX)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_meta(input string tag, input int a3, input int res, input int tnew);
    check({tag, ".A3"},   32'(A3_IDEX),   32'(a3));
    check({tag, ".Res"},  32'(Res_IDEX),  32'(res));
    check({tag, ".Tnew"}, 32'(Tnew_IDEX), 32'(tnew));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    logic [31:0] ir;
    logic [4:0]  rs, rt, rd;
    int          dest, cls, tn, kind;

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    IR_IFID = rtype(6'h21, 5'd1, 5'd2, 5'd3);
    PCp4_IFID = 32'h3008; BD_IFID = 1'b1; ExcCode_IFID = 5'd0;
    RD1_ID = 32'h1111_1111; RD2_ID = 32'h2222_2222; EXT_ID = 32'h0000_0005;

    // reset held two cycles: stage reads as a NOP
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst.IR", IR_IDEX, 32'h0);
      check("rst.PCp4", PCp4_IDEX, 32'h3004);
      check("rst.RS", RS_IDEX, 32'h0);
      check("rst.BD", 32'(BD_IDEX), 32'h0);
      check_meta("rst", 0, 0, 0);
    end
    reset = 1'b0;
    step();
    check_meta("addu", 3, 1, 1);
    check("addu.A1", 32'(A1_IDEX), 32'd1);
    check("addu.A2", 32'(A2_IDEX), 32'd2);
    check("addu.IR", IR_IDEX, 32'h0022_1821);
    check("addu.RT", RT_IDEX, 32'h2222_2222);
    check("addu.PCp4", PCp4_IDEX, 32'h3008);

    // lw $5,4($6)
    IR_IFID = itype(6'h23, 5'd6, 5'd5, 16'd4); PCp4_IFID = 32'h3010; BD_IFID = 1'b0;
    step();
    check("lw.A1", 32'(A1_IDEX), 32'd6);
    check("lw.A2", 32'(A2_IDEX), 32'd5);
    check_meta("lw", 5, 2, 2);
    check("lw.PCp4", PCp4_IDEX, 32'h3010);
    check("lw.EXT", EXT_IDEX, 32'h5);

    // jal under stall becomes a bubble carrying PC+4/BD
    IR_IFID = {6'h03, 26'h000_0100}; PCp4_IFID = 32'h3020; BD_IFID = 1'b1; stall = 1'b1;
    step();
    check("stall.IR", IR_IDEX, 32'h0);
    check_meta("stall", 0, 0, 0);
    check("stall.RS", RS_IDEX, 32'h0);
    check("stall.PCp4", PCp4_IDEX, 32'h3020);
    check("stall.BD", 32'(BD_IDEX), 32'h1);

    // stall and flush together: flush wins
    PCp4_IFID = 32'h3030; flush = 1'b1;
    step();
    check("sf.IR", IR_IDEX, 32'h0);
    check("sf.BD", 32'(BD_IDEX), 32'h0);
    check("sf.PCp4", PCp4_IDEX, 32'h3004);
    stall = 1'b0; flush = 1'b0;

    // jal without stall
    IR_IFID = {6'h03, 26'h000_0100}; BD_IFID = 1'b0;
    step();
    check_meta("jal", 31, 3, 0);

    // unrecognised opcode
    IR_IFID = {6'h3f, 5'd1, 5'd7, 16'h0}; ExcCode_IFID = 5'd0;
    step();
    check("ri.Exc", 32'(ExcCode_IDEX), 32'd10);
    check_meta("ri", 0, 0, 0);
    ExcCode_IFID = 5'd4;
    step();
    check("riup.Exc", 32'(ExcCode_IDEX), 32'd4);
    check("riup.A3", 32'(A3_IDEX), 32'd0);
    ExcCode_IFID = 5'd0;

    // sll $0 is a legal NOP
    IR_IFID = 32'h0;
    step();
    check("nop.Exc", 32'(ExcCode_IDEX), 32'd0);
    check_meta("nop", 0, 0, 0);

    // addiu $0,$1,5: forced zero destination
    IR_IFID = itype(6'h09, 5'd1, 5'd0, 16'd5);
    step();
    check_meta("addiu0", 0, 0, 0);
    check("addiu0.Exc", 32'(ExcCode_IDEX), 32'd0);

    // random legal instructions, expected class from the bench's own table
    for (int n = 0; n < 10; n++) begin
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      kind = int'($urandom_range(0, 16));
      case (kind)
        0:  begin ir = rtype(6'h21, rs, rt, rd); dest = int'(rd); cls = 1; end
        1:  begin ir = rtype(6'h23, rs, rt, rd); dest = int'(rd); cls = 1; end
        2:  begin ir = rtype(6'h25, rs, rt, rd); dest = int'(rd); cls = 1; end
        3:  begin ir = rtype(6'h2a, rs, rt, rd); dest = int'(rd); cls = 1; end
        4:  begin ir = rtype(6'h00, 5'd0, rt, rd) | 32'h0000_0140; dest = int'(rd); cls = 1; end
        5:  begin ir = itype(6'h09, rs, rt, 16'h1234); dest = int'(rt); cls = 1; end
        6:  begin ir = itype(6'h0d, rs, rt, 16'h00ff); dest = int'(rt); cls = 1; end
        7:  begin ir = itype(6'h0f, 5'd0, rt, 16'h8000); dest = int'(rt); cls = 1; end
        8:  begin ir = itype(6'h23, rs, rt, 16'h0008); dest = int'(rt); cls = 2; end
        9:  begin ir = itype(6'h24, rs, rt, 16'hfffc); dest = int'(rt); cls = 2; end
        10: begin ir = {6'h10, 5'd0, rt, rd, 11'd0}; dest = int'(rt); cls = 2; end
        11: begin ir = {6'h03, rs, rt, 16'h0040}; dest = 31; cls = 3; end
        12: begin ir = rtype(6'h09, rs, 5'd0, rd); dest = int'(rd); cls = 3; end
        13: begin ir = itype(6'h2b, rs, rt, 16'h0010); dest = 0; cls = 0; end
        14: begin ir = itype(6'h04, rs, rt, 16'h0003); dest = 0; cls = 0; end
        15: begin ir = rtype(6'h18, rs, rt, 5'd0); dest = 0; cls = 0; end
        default: begin ir = 32'h4200_0018; dest = 0; cls = 0; end
      endcase
      tn = (cls == 1) ? 1 : (cls == 2) ? 2 : 0;
      if (dest == 0) begin cls = 0; tn = 0; end
      IR_IFID = ir;
      RD1_ID = $urandom;
      step();
      check($sformatf("rnd%0d.IR", n), IR_IDEX, ir);
      check($sformatf("rnd%0d.A1", n), 32'(A1_IDEX), 32'(ir[25:21]));
      check($sformatf("rnd%0d.A2", n), 32'(A2_IDEX), 32'(ir[20:16]));
      check_meta($sformatf("rnd%0d", n), dest, cls, tn);
      check($sformatf("rnd%0d.Exc", n), 32'(ExcCode_IDEX), 32'd0);
    end

    // flush alone kills a loaded instruction
    IR_IFID = itype(6'h23, 5'd2, 5'd9, 16'd0); BD_IFID = 1'b1; flush = 1'b1;
    step();
    check_meta("flush", 0, 0, 0);
    check("flush.PCp4", PCp4_IDEX, 32'h3004);
    check("flush.BD", 32'(BD_IDEX), 32'h0);
    flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
